// File: rtl/hazard_forward_unit_if.sv
// Hazard/forwarding bus between the decode stage and hazard_forward_unit.
//
// Handshake: i_issue_valid has no ready companion. o_stall acts as the
// inverse of ready. An instruction presented with i_issue_valid=1 is
// accepted on a rising edge only when o_stall=0 and i_flush=0. While
// o_stall=1 the decode stage must hold the same instruction, and the unit
// inserts a bubble into stage 0.
//
// Signals (master = decode side, slave = hazard_forward_unit):
//   i_issue_valid/we/wra/load : instruction leaving decode
//   i_flush                   : kill the instruction in decode
//   i_ra / i_rd               : packed read addresses / register-file data
//   i_stage_data              : result bus of each tracked stage (slice k = stage k)
//   o_rd / o_fwd_hit          : forwarded read data / per-port forward flag
//   o_stall / o_stall_cnt     : decode hold / saturating stall-cycle count
interface hazard_forward_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3
);
  logic                       i_issue_valid;
  logic                       i_issue_we;
  logic [ADDR_W-1:0]          i_issue_wra;
  logic                       i_issue_load;
  logic                       i_flush;
  logic [NUM_RD*ADDR_W-1:0]   i_ra;
  logic [NUM_RD*DATA_W-1:0]   i_rd;
  logic [DEPTH*DATA_W-1:0]    i_stage_data;
  logic [NUM_RD*DATA_W-1:0]   o_rd;
  logic [NUM_RD-1:0]          o_fwd_hit;
  logic                       o_stall;
  logic [15:0]                o_stall_cnt;

  modport master (
    output i_issue_valid, i_issue_we, i_issue_wra, i_issue_load, i_flush,
    output i_ra, i_rd, i_stage_data,
    input  o_rd, o_fwd_hit, o_stall, o_stall_cnt
  );

  modport slave (
    input  i_issue_valid, i_issue_we, i_issue_wra, i_issue_load, i_flush,
    input  i_ra, i_rd, i_stage_data,
    output o_rd, o_fwd_hit, o_stall, o_stall_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: tracks destination registers of the DEPTH stages after
// decode, forwards in-flight results to the register read ports, and stalls
// decode on load-use hazards.
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset (clears queue and stall counter)
//   bus  : hazard_forward_unit_if.slave (see interface file for signals)
//
// Configuration macro HAZARD_FWD_EN:
//   defined   -> full forwarding; stall only on load-use with the stage-0 entry
//   undefined -> interlock-only; no forwarding, stall on any match with any
//                valid entry while an instruction is issuing
module hazard_forward_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_unit_if.slave bus
);

  // Shift queue: index 0 is the youngest (E), DEPTH-1 the oldest (W).
  logic [DEPTH-1:0]             q_valid;
  logic [DEPTH-1:0]             q_load;
  logic [DEPTH-1:0][ADDR_W-1:0] q_wra;

  logic [NUM_RD-1:0][DEPTH-1:0] match;
  logic                         stall;
  logic [15:0]                  stall_cnt;

  // Entry that enters stage 0 on the next edge. It is a bubble when decode is
  // held or flushed. Writes to r0 are tracked as invalid so they never match.
  logic                         new_valid;
  logic [ADDR_W-1:0]            new_wra;
  logic                         new_load;

  always_comb begin
    match = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        match[p][k] = q_valid[k]
                    && (q_wra[k] == bus.i_ra[p*ADDR_W +: ADDR_W])
                    && (bus.i_ra[p*ADDR_W +: ADDR_W] != '0);
      end
    end
  end

`ifdef HAZARD_FWD_EN
  logic [NUM_RD*DATA_W-1:0] rd_fwd;
  logic [NUM_RD-1:0]        hit;
  logic                     load_use;
  logic                     unused_oldest_load;

  // Walk from oldest to youngest so the youngest matching stage is written last.
  always_comb begin
    rd_fwd   = bus.i_rd;
    hit      = '0;
    load_use = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (match[p][k]) begin
          rd_fwd[p*DATA_W +: DATA_W] = bus.i_stage_data[k*DATA_W +: DATA_W];
        end
      end
      hit[p]   = |match[p];
      load_use = load_use | (match[p][0] & q_load[0]);
    end
  end

  assign stall              = bus.i_issue_valid & load_use;
  assign bus.o_rd           = rd_fwd;
  assign bus.o_fwd_hit      = hit;
  // The oldest entry's load flag is shifted out without ever being read.
  assign unused_oldest_load = q_load[DEPTH-1];
`else
  logic unused_interlock;

  // Without forwarding, any in-flight producer must retire before the read.
  assign stall            = bus.i_issue_valid & (|match);
  assign bus.o_rd         = bus.i_rd;
  assign bus.o_fwd_hit    = '0;
  assign unused_interlock = ^{bus.i_stage_data, q_load};
`endif

  always_comb begin
    new_valid = 1'b0;
    new_wra   = '0;
    new_load  = 1'b0;
    if (!stall && !bus.i_flush) begin
      new_valid = bus.i_issue_valid & bus.i_issue_we & (bus.i_issue_wra != '0);
      new_wra   = bus.i_issue_wra;
      new_load  = bus.i_issue_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid   <= '0;
      q_load    <= '0;
      q_wra     <= '0;
      stall_cnt <= '0;
    end else begin
      q_valid <= {q_valid[DEPTH-2:0], new_valid};
      q_load  <= {q_load[DEPTH-2:0], new_load};
      q_wra   <= {q_wra[DEPTH-2:0], new_wra};
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign bus.o_stall     = stall;
  assign bus.o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit (default parameters).
// A queue-based model of the tracked instructions predicts every output on
// each falling edge; directed vectors additionally pin literal values.
module tb_hazard_forward_unit;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 3;

  localparam logic [31:0] S0 = 32'h0000_1234;
  localparam logic [31:0] S1 = 32'hAAAA_0001;
  localparam logic [31:0] S2 = 32'hCCCC_0002;
  localparam logic [31:0] R0 = 32'hD000_0000;
  localparam logic [31:0] R1 = 32'hD111_1111;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  hazard_forward_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .DEPTH(DEPTH)) bus ();

  hazard_forward_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    bit          v;
    int unsigned wra;
    bit          ld;
  } ent_t;

  ent_t mq[$];
  int   m_cnt;
  bit   model_live = 1'b0;

  // Expected outputs for the current inputs and tracked instructions.
  task automatic model_eval(output logic [NUM_RD*DATA_W-1:0] e_rd,
                            output logic [NUM_RD-1:0] e_hit,
                            output logic e_stall);
    int unsigned a;
    int          youngest;
    bit          any_match;
    bit          load_use;
    e_rd      = bus.i_rd;
    e_hit     = '0;
    any_match = 1'b0;
    load_use  = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      a        = int'(bus.i_ra[p*ADDR_W +: ADDR_W]);
      youngest = -1;
      if (a != 0) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (mq[k].v && mq[k].wra == a && youngest < 0) youngest = k;
        end
      end
      if (youngest >= 0) begin
        any_match = 1'b1;
        if (youngest == 0 && mq[0].ld) load_use = 1'b1;
`ifdef HAZARD_FWD_EN
        e_hit[p] = 1'b1;
        e_rd[p*DATA_W +: DATA_W] = bus.i_stage_data[youngest*DATA_W +: DATA_W];
`endif
      end
    end
`ifdef HAZARD_FWD_EN
    e_stall = bus.i_issue_valid & load_use;
`else
    e_stall = bus.i_issue_valid & any_match;
`endif
  endtask

  always @(posedge clk) begin
    logic [NUM_RD*DATA_W-1:0] e_rd;
    logic [NUM_RD-1:0]        e_hit;
    logic                     e_stall;
    ent_t                     e;
    if (rst) begin
      mq = {};
      for (int k = 0; k < DEPTH; k++) mq.push_back('{v: 1'b0, wra: 0, ld: 1'b0});
      m_cnt      = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      model_eval(e_rd, e_hit, e_stall);
      e.v   = !e_stall && !bus.i_flush && bus.i_issue_valid && bus.i_issue_we
              && (bus.i_issue_wra != '0);
      e.wra = int'(bus.i_issue_wra);
      e.ld  = bus.i_issue_load;
      mq.push_front(e);
      void'(mq.pop_back());
      if (e_stall && m_cnt < 65535) m_cnt++;
    end
  end

  always @(negedge clk) begin
    logic [NUM_RD*DATA_W-1:0] e_rd;
    logic [NUM_RD-1:0]        e_hit;
    logic                     e_stall;
    if (model_live) begin
      model_eval(e_rd, e_hit, e_stall);
      chk("cyc_rd",    128'(bus.o_rd),        128'(e_rd));
      chk("cyc_hit",   128'(bus.o_fwd_hit),   128'(e_hit));
      chk("cyc_stall", 128'(bus.o_stall),     128'(e_stall));
      chk("cyc_cnt",   128'(bus.o_stall_cnt), 128'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    bus.i_issue_valid = 1'b0;
    bus.i_issue_we    = 1'b0;
    bus.i_issue_wra   = '0;
    bus.i_issue_load  = 1'b0;
    bus.i_flush       = 1'b0;
    bus.i_ra          = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic drain();
    repeat (DEPTH) step();
  endtask

  task automatic issue(input logic [ADDR_W-1:0] wra, input logic ld);
    bus.i_issue_valid = 1'b1;
    bus.i_issue_we    = 1'b1;
    bus.i_issue_wra   = wra;
    bus.i_issue_load  = ld;
  endtask

  // A non-writing instruction in decode reading two registers.
  task automatic rd_req(input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1);
    bus.i_issue_valid = 1'b1;
    bus.i_issue_we    = 1'b0;
    bus.i_ra          = {ra1, ra0};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_in();
    bus.i_rd         = {R1, R0};
    bus.i_stage_data = {S2, S1, S0};

    // Reset with a write to r3 presented: reset must override it.
    rst = 1'b1;
    issue(5'd3, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_in();
    bus.i_ra = {5'd0, 5'd3};
    @(negedge clk);
    chk("rst_stall", 128'(bus.o_stall), 128'(0));
    chk("rst_hit",   128'(bus.o_fwd_hit), 128'(0));
    chk("rst_rd",    128'(bus.o_rd), 128'({R1, R0}));
    chk("rst_cnt",   128'(bus.o_stall_cnt), 128'(0));
    drain();

    // r3 ALU write, read next cycle.
    step(); issue(5'd3, 1'b0);
    step(); rd_req(5'd3, 5'd0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("alu_rd0",   128'(bus.o_rd[31:0]), 128'(S0));
    chk("alu_hit",   128'(bus.o_fwd_hit), 128'(2'b01));
    chk("alu_stall", 128'(bus.o_stall), 128'(0));
`else
    chk("alu_rd0",   128'(bus.o_rd[31:0]), 128'(R0));
    chk("alu_hit",   128'(bus.o_fwd_hit), 128'(0));
    chk("alu_stall", 128'(bus.o_stall), 128'(1));
`endif
    drain();

    // Load to r5 followed by a dependent read on port 1.
    step(); issue(5'd5, 1'b1);
    step(); rd_req(5'd0, 5'd5);
    @(negedge clk);
    chk("lu_stall1", 128'(bus.o_stall), 128'(1));
    step(); rd_req(5'd0, 5'd5);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("lu_stall2", 128'(bus.o_stall), 128'(0));
    chk("lu_rd1",    128'(bus.o_rd[63:32]), 128'(S1));
    chk("lu_hit",    128'(bus.o_fwd_hit), 128'(2'b10));
    chk("lu_cnt",    128'(bus.o_stall_cnt), 128'(1));
`else
    chk("lu_stall2", 128'(bus.o_stall), 128'(1));
    chk("lu_cnt",    128'(bus.o_stall_cnt), 128'(2));
`endif
    step(); rd_req(5'd0, 5'd5);
    drain();

    // r7 in stages 0 and 2, r1 in stage 1.
    step(); issue(5'd7, 1'b0);
    step(); issue(5'd1, 1'b0);
    step(); issue(5'd7, 1'b0);
    step(); rd_req(5'd7, 5'd1);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("yw_rd",    128'(bus.o_rd), 128'({S1, S0}));
    chk("yw_hit",   128'(bus.o_fwd_hit), 128'(2'b11));
    chk("yw_stall", 128'(bus.o_stall), 128'(0));
`else
    chk("yw_stall", 128'(bus.o_stall), 128'(1));
    chk("yw_hit",   128'(bus.o_fwd_hit), 128'(0));
`endif
    drain();

    // Load to r0 then read r0 on both ports.
    step(); issue(5'd0, 1'b1);
    step(); rd_req(5'd0, 5'd0);
    @(negedge clk);
    chk("r0_hit",   128'(bus.o_fwd_hit), 128'(0));
    chk("r0_rd",    128'(bus.o_rd), 128'({R1, R0}));
    chk("r0_stall", 128'(bus.o_stall), 128'(0));
    drain();

    // Flushed load to r4 never becomes a producer.
    step(); issue(5'd4, 1'b1); bus.i_flush = 1'b1;
    step(); rd_req(5'd4, 5'd0);
    @(negedge clk);
    chk("fl_stall", 128'(bus.o_stall), 128'(0));
    chk("fl_hit",   128'(bus.o_fwd_hit), 128'(0));
    chk("fl_rd0",   128'(bus.o_rd[31:0]), 128'(R0));
    drain();

    // Reset during a load-use stall.
    step(); issue(5'd6, 1'b1);
    step(); rd_req(5'd6, 5'd0); rst = 1'b1;
    @(negedge clk);
    chk("rs_stall_pre", 128'(bus.o_stall), 128'(1));
    step(); rd_req(5'd6, 5'd0); rst = 1'b0;
    @(negedge clk);
    chk("rs_stall", 128'(bus.o_stall), 128'(0));
    chk("rs_cnt",   128'(bus.o_stall_cnt), 128'(0));
    chk("rs_hit",   128'(bus.o_fwd_hit), 128'(0));
    drain();

    // r2 written, then read one, two and three cycles later, then once more.
    step(); issue(5'd2, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      step(); rd_req(5'd2, 5'd0);
      @(negedge clk);
`ifdef HAZARD_FWD_EN
      chk("r2_stall", 128'(bus.o_stall), 128'(0));
      chk("r2_hit",   128'(bus.o_fwd_hit), 128'(2'b01));
      chk("r2_rd0",   128'(bus.o_rd[31:0]), 128'(bus.i_stage_data[k*DATA_W +: DATA_W]));
`else
      chk("r2_stall", 128'(bus.o_stall), 128'(1));
      chk("r2_hit",   128'(bus.o_fwd_hit), 128'(0));
`endif
    end
    step(); rd_req(5'd2, 5'd0);
    @(negedge clk);
    chk("r2_done_stall", 128'(bus.o_stall), 128'(0));
    chk("r2_done_hit",   128'(bus.o_fwd_hit), 128'(0));
    drain();

    // Flush and stall together: one bubble, count still advances.
    step(); issue(5'd8, 1'b1);
    step(); rd_req(5'd8, 5'd0); bus.i_flush = 1'b1;
    @(negedge clk);
    chk("fs_stall", 128'(bus.o_stall), 128'(1));
    step();
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("fs_cnt", 128'(bus.o_stall_cnt), 128'(1));
`else
    chk("fs_cnt", 128'(bus.o_stall_cnt), 128'(4));
`endif
    drain();

    // Mixed traffic on a small register range; the model checks each cycle.
    for (int i = 0; i < 80; i++) begin
      step();
      bus.i_issue_valid = 1'($urandom_range(0, 1));
      bus.i_issue_we    = 1'($urandom_range(0, 1));
      bus.i_issue_wra   = 5'($urandom_range(0, 3));
      bus.i_issue_load  = 1'($urandom_range(0, 1));
      bus.i_flush       = ($urandom_range(0, 7) == 0);
      bus.i_ra          = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      bus.i_rd          = {$urandom(), $urandom()};
      bus.i_stage_data  = {$urandom(), $urandom(), $urandom()};
    end
    step();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter DATA_W, default 32, width of register data.
REQ-002 Parameter ADDR_W, default 5, width of register address; address 0 is the hard-wired zero register.
REQ-003 Parameter NUM_RD, default 2, number of register read ports served.
REQ-004 Parameter DEPTH, default 3, number of tracked pipeline stages after decode (index 0 = E, 1 = M, ..., DEPTH-1 = W); legal range 2..8.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_issue_valid  input  1  decode stage presents a valid instruction this cycle.
REQ-008 i_issue_we  input  1  issued instruction writes a register.
REQ-009 i_issue_wra  input  ADDR_W  destination register of the issued instruction.
REQ-010 i_issue_load  input  1  issued instruction is a load; its result is first valid at stage 1.
REQ-011 i_flush  input  1  kill the instruction currently in decode; it does not enter stage 0.
REQ-012 i_ra  input  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-013 i_rd  input  NUM_RD*DATA_W  register-file read data, packed the same way.
REQ-014 i_stage_data  input  DEPTH*DATA_W  result bus of each tracked stage; slice k carries stage k (E ALU result, M memory/ALU result, W write-back value).
REQ-015 o_rd  output  NUM_RD*DATA_W  forwarded read data per port.
REQ-016 o_fwd_hit  output  NUM_RD  port p is sourced from a stage rather than from i_rd.
REQ-017 o_stall  output  1  hold decode; insert a bubble into stage 0.
REQ-018 o_stall_cnt  output  16  count of stall cycles since reset.

Function
REQ-019 The block shall keep a DEPTH-entry shift queue; each entry holds {valid, wra, load}.
REQ-020 Every cycle without rst, entry k shall take entry k-1 for k = 1..DEPTH-1; the oldest entry is discarded.
REQ-021 Entry 0 shall take {i_issue_valid & i_issue_we & (i_issue_wra != 0), i_issue_wra, i_issue_load} when o_stall = 0 and i_flush = 0; otherwise it shall take an invalid bubble.
REQ-022 Port p shall match entry k when entry k is valid and its wra equals i_ra[p] and i_ra[p] != 0.
REQ-023 Matching is combinational with zero latency; o_rd[p] shall be i_stage_data slice of the lowest-index (youngest) matching entry, else i_rd[p].
REQ-024 o_fwd_hit[p] shall be 1 exactly when any entry matches port p.
REQ-025 o_stall shall be 1 when i_issue_valid = 1 and any port matches entry 0 with load = 1 (load-use hazard).
REQ-026 A port whose address is 0 shall never match, forward, or stall; o_rd[p] = i_rd[p].
REQ-027 When i_flush and o_stall are both 1, the bubble is inserted once and the stall count still increments.
REQ-028 o_stall_cnt shall increment by 1 on each rising edge where o_stall = 1, and saturate at 16'hFFFF.
REQ-029 A stall resolves after one cycle: the load advances to stage 1 and the dependent read then forwards from slice 1.

Reset
REQ-030 When rst = 1 at a rising edge, all queue entries shall become invalid and o_stall_cnt shall become 0, overriding issue and flush.
REQ-031 After reset: o_stall = 0, o_fwd_hit = 0, and o_rd = i_rd.
REQ-032 Reset asserted mid-stall shall drop the stall in the following cycle; no pending hazard survives reset.

Configuration
REQ-033 Macro HAZARD_FWD_EN: when defined, forwarding and stalling follow REQ-023..REQ-025.
REQ-034 When HAZARD_FWD_EN is undefined, the block runs in interlock-only mode: o_rd = i_rd and o_fwd_hit = 0 always, and o_stall = 1 whenever i_issue_valid = 1 and any port matches any valid entry.

Verification
REQ-035 Issue r3 write (non-load); next cycle i_ra[0] = 3 with i_stage_data slice 0 = 32'h1234 -> o_rd[0] = 32'h1234, o_fwd_hit[0] = 1, o_stall = 0.
REQ-036 Issue load to r5; next cycle i_ra[1] = 5 -> o_stall = 1 for exactly one cycle, then o_rd[1] = slice 1 value, o_stall_cnt = 1.
REQ-037 r7 written in both stage 0 and stage 2, read r7 -> slice 0 value is selected (youngest wins).
REQ-038 Issue write to r0, then read r0 -> o_fwd_hit = 0, o_rd = i_rd, no stall.
REQ-039 Load to r4 with i_flush = 1, then read r4 -> no stall and no forward; assert rst during a stall -> next cycle o_stall = 0 and o_stall_cnt = 0.
REQ-040 With HAZARD_FWD_EN undefined, write r2 and read r2 one, two, and three cycles later -> o_stall = 1 while r2 is in the queue, and o_fwd_hit = 0 throughout.
